// File: rtl/pipeline_ctrl_unit_if.sv
// pipeline_ctrl_unit_if: hazard/control bundle between the datapath and the pipeline control unit
//   datapath -> ctrl : id_unlock, if_busy, ex_busy, am_busy, am_exception, am_exception_pc
//   ctrl -> datapath : if/id/ex/am_stall, id/ex/am/wb_valid, flush, pc_load, pc_load_addr
interface pipeline_ctrl_unit_if;
   logic        id_unlock;
   logic        if_busy;
   logic        ex_busy;
   logic        am_busy;
   logic        am_exception;
   logic [31:0] am_exception_pc;
   logic        if_stall;
   logic        id_stall;
   logic        ex_stall;
   logic        am_stall;
   logic        id_valid;
   logic        ex_valid;
   logic        am_valid;
   logic        wb_valid;
   logic        flush;
   logic        pc_load;
   logic [31:0] pc_load_addr;
   modport master (
      output id_unlock, if_busy, ex_busy, am_busy, am_exception, am_exception_pc,
      input  if_stall, id_stall, ex_stall, am_stall, id_valid, ex_valid, am_valid, wb_valid,
             flush, pc_load, pc_load_addr
   );
   modport slave (
      input  id_unlock, if_busy, ex_busy, am_busy, am_exception, am_exception_pc,
      output if_stall, id_stall, ex_stall, am_stall, id_valid, ex_valid, am_valid, wb_valid,
             flush, pc_load, pc_load_addr
   );
endinterface

// File: rtl/pipeline_ctrl_unit.sv
// pipeline_ctrl_unit: stall/bubble/flush control and stage-valid tracking for the 5-stage IF/ID/EX/AM/WB core
//   clk, rst  : core clock, synchronous active-high reset
//   p         : slave side of pipeline_ctrl_unit_if (busy/interlock/exception in; stalls, valids, flush, PC redirect out)
//   stall_cnt : saturating count of cycles with if_stall asserted
module pipeline_ctrl_unit #(
   parameter int          CNT_W    = 32,
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic             clk,
   input  logic             rst,
   pipeline_ctrl_unit_if.slave p,
   output logic [CNT_W-1:0] stall_cnt
);
   typedef enum logic {RUN, DISCARD} state_t;
   state_t state, state_n;
   logic boot, exc, c_am, c_ex, c_id, c_if;
   logic id_v, ex_v, am_v, wb_v;
   logic id_n, ex_n, am_n, wb_n;
   logic if_s, id_s, ex_s, am_s;
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         boot      <= 1'b1;
         {id_v, ex_v, am_v, wb_v} <= 4'b0;
         stall_cnt <= '0;
      end else begin
         state <= state_n;
         boot  <= 1'b0;
         {id_v, ex_v, am_v, wb_v} <= {id_n, ex_n, am_n, wb_n};
         if (if_s && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end
   always_comb begin
      exc  = p.am_exception & am_v;
      c_am = p.am_busy & am_v;
      c_ex = p.ex_busy & ex_v;
      c_id = ~p.id_unlock & id_v;
      c_if = p.if_busy | (state == DISCARD);
      // each cause stalls its own stage and everything upstream; an exception overrides all stalls
      am_s = ~exc & c_am;
      ex_s = ~exc & (c_am | c_ex);
      id_s = ~exc & (c_am | c_ex | c_id);
      if_s = ~exc & (c_am | c_ex | c_id | c_if);
      // a stalled stage holds; a running stage behind a stalled one takes a bubble; IF running means a fetch landed
      id_n = exc ? 1'b0 : id_s ? id_v : ~if_s;
      ex_n = exc ? 1'b0 : ex_s ? ex_v : (id_s ? 1'b0 : id_v);
      am_n = exc ? 1'b0 : am_s ? am_v : (ex_s ? 1'b0 : ex_v);
      wb_n = exc ? 1'b0 : am_s ? 1'b0 : am_v;
      // an outstanding fetch at flush time returns a word from the squashed path, which must be dropped
      state_n = exc ? ((p.if_busy || state == DISCARD) ? DISCARD : RUN)
                    : ((state == DISCARD && p.if_busy) ? DISCARD : RUN);
   end
   assign p.if_stall     = if_s;
   assign p.id_stall     = id_s;
   assign p.ex_stall     = ex_s;
   assign p.am_stall     = am_s;
   assign p.id_valid     = id_v;
   assign p.ex_valid     = ex_v;
   assign p.am_valid     = am_v;
   assign p.wb_valid     = wb_v;
   assign p.flush        = exc;
   assign p.pc_load      = exc | boot;
   assign p.pc_load_addr = exc ? p.am_exception_pc : RESET_PC;
endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// tb_pipeline_ctrl_unit: table-driven check of pipeline_ctrl_unit with a scoreboard for registered outputs
module tb_pipeline_ctrl_unit;
   typedef struct {
      logic        unl, ifb, exb, amb, exc;
      logic [31:0] epc;
      logic [3:0]  stl;
      logic        fl, pcl;
      logic [31:0] pca;
      logic [3:0]  vld;
      logic [31:0] cnt;
   } vec_t;
   typedef struct {
      logic [3:0]  vld;
      logic [31:0] cnt;
      int          idx;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rst_s = 1'b1;
   logic [31:0] stall_cnt;
   logic [3:0]  cnt_s;
   int          checks = 0;
   int          failures = 0;
   vec_t        tbl[$];
   exp_t        sb[$];
   pipeline_ctrl_unit_if p ();
   pipeline_ctrl_unit_if s ();
   pipeline_ctrl_unit u_dut (.clk(clk), .rst(rst), .p(p.slave), .stall_cnt(stall_cnt));
   pipeline_ctrl_unit #(.CNT_W(4)) u_sat (.clk(clk), .rst(rst_s), .p(s.slave), .stall_cnt(cnt_s));
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask
   task automatic add(input logic unl, ifb, exb, amb, exc, input logic [31:0] epc,
                      input logic [3:0] stl, input logic fl, pcl, input logic [31:0] pca,
                      input logic [3:0] vld, input logic [31:0] cnt);
      vec_t v;
      v = '{unl, ifb, exb, amb, exc, epc, stl, fl, pcl, pca, vld, cnt};
      tbl.push_back(v);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      vec_t v;
      exp_t e;
      {p.id_unlock, p.if_busy, p.ex_busy, p.am_busy, p.am_exception} = 5'b10000;
      p.am_exception_pc = 32'h0;
      {s.id_unlock, s.if_busy, s.ex_busy, s.am_busy, s.am_exception} = 5'b11000;
      s.am_exception_pc = 32'h0;
      // stalls {if,id,ex,am}; valids {id,ex,am,wb}
      add(1,0,0,0,0, 0,            4'b0000, 0, 1, 32'hBFC0_0000, 4'b1000, 0);
      add(1,0,0,0,0, 0,            4'b0000, 0, 0, 0,             4'b1100, 0);
      add(1,0,0,0,0, 0,            4'b0000, 0, 0, 0,             4'b1110, 0);
      add(1,0,0,0,0, 0,            4'b0000, 0, 0, 0,             4'b1111, 0);
      add(0,0,0,0,0, 0,            4'b1100, 0, 0, 0,             4'b1011, 1);
      add(1,0,0,0,0, 0,            4'b0000, 0, 0, 0,             4'b1101, 1);
      add(1,0,0,0,0, 0,            4'b0000, 0, 0, 0,             4'b1110, 1);
      add(1,0,0,0,0, 0,            4'b0000, 0, 0, 0,             4'b1111, 1);
      add(0,0,1,0,0, 0,            4'b1110, 0, 0, 0,             4'b1101, 2);
      add(0,0,1,0,0, 0,            4'b1110, 0, 0, 0,             4'b1100, 3);
      add(0,0,1,0,0, 0,            4'b1110, 0, 0, 0,             4'b1100, 4);
      add(0,0,1,0,0, 0,            4'b1110, 0, 0, 0,             4'b1100, 5);
      add(1,0,0,0,0, 0,            4'b0000, 0, 0, 0,             4'b1110, 5);
      add(1,0,0,0,0, 0,            4'b0000, 0, 0, 0,             4'b1111, 5);
      add(1,1,0,0,1, 32'hBFC0_0380, 4'b0000, 1, 1, 32'hBFC0_0380, 4'b0000, 5);
      add(1,1,0,0,0, 0,            4'b1000, 0, 0, 0,             4'b0000, 6);
      add(1,1,0,0,0, 0,            4'b1000, 0, 0, 0,             4'b0000, 7);
      add(1,1,0,0,0, 0,            4'b1000, 0, 0, 0,             4'b0000, 8);
      add(1,0,0,0,0, 0,            4'b1000, 0, 0, 0,             4'b0000, 9);
      add(1,0,0,0,0, 0,            4'b0000, 0, 0, 0,             4'b1000, 9);
      add(1,0,0,0,0, 0,            4'b0000, 0, 0, 0,             4'b1100, 9);
      add(1,0,1,1,1, 32'h0000_1234, 4'b1110, 0, 0, 0,             4'b1100, 10);
      add(1,0,0,1,0, 0,            4'b0000, 0, 0, 0,             4'b1110, 10);
      add(1,0,1,1,0, 0,            4'b1111, 0, 0, 0,             4'b1110, 11);
      add(1,0,0,0,0, 0,            4'b0000, 0, 0, 0,             4'b1111, 11);
      add(1,0,0,0,1, 32'h8000_0180, 4'b0000, 1, 1, 32'h8000_0180, 4'b0000, 11);
      add(1,0,0,0,0, 0,            4'b0000, 0, 0, 0,             4'b1000, 11);
      add(1,0,0,0,0, 0,            4'b0000, 0, 0, 0,             4'b1100, 11);
      @(posedge clk);
      #1 rst = 1'b0;
      chk("reset valids", {p.id_valid, p.ex_valid, p.am_valid, p.wb_valid}, 4'b0000);
      chk("reset stall_cnt", stall_cnt, 0);
      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         {p.id_unlock, p.if_busy, p.ex_busy, p.am_busy, p.am_exception} = {v.unl, v.ifb, v.exb, v.amb, v.exc};
         p.am_exception_pc = v.epc;
         @(negedge clk);
         chk($sformatf("row%0d stalls", i), {p.if_stall, p.id_stall, p.ex_stall, p.am_stall}, v.stl);
         chk($sformatf("row%0d flush", i), p.flush, v.fl);
         chk($sformatf("row%0d pc_load", i), p.pc_load, v.pcl);
         if (v.pcl) chk($sformatf("row%0d pc_load_addr", i), p.pc_load_addr, v.pca);
         sb.push_back('{v.vld, v.cnt, i});
         @(posedge clk);
         #1;
         e = sb.pop_front();
         chk($sformatf("row%0d valids", e.idx), {p.id_valid, p.ex_valid, p.am_valid, p.wb_valid}, e.vld);
         chk($sformatf("row%0d stall_cnt", e.idx), stall_cnt, e.cnt);
      end
      // reset in the middle of a running pipeline
      {p.id_unlock, p.if_busy, p.ex_busy, p.am_busy, p.am_exception} = 5'b10000;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("midrst valids", {p.id_valid, p.ex_valid, p.am_valid, p.wb_valid}, 4'b0000);
      chk("midrst stall_cnt", stall_cnt, 0);
      @(negedge clk);
      chk("midrst pc_load", p.pc_load, 1);
      chk("midrst pc_load_addr", p.pc_load_addr, 32'hBFC0_0000);
      chk("midrst flush", p.flush, 0);
      // saturation on a 4-bit counter: fetch held busy, so every cycle is an IF stall
      @(posedge clk);
      #1 rst_s = 1'b0;
      chk("sat reset", cnt_s, 0);
      repeat (14) @(posedge clk);
      #1 chk("sat 14", cnt_s, 4'hE);
      repeat (3) @(posedge clk);
      #1 chk("sat hold", cnt_s, 4'hF);
      rst_s = 1'b1;
      @(posedge clk);
      #1 chk("sat clear", cnt_s, 4'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
